// File: rtl/uart_rx_engine_if.sv
// Processor-side port of the UART receive engine: received character,
// status flags and the ready/read handshake.
interface uart_rx_engine_if;
    logic [7:0] data;
    logic       rx_rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;
    logic       busy;
    logic       rd_strobe;

    modport master (
        output data, rx_rdy, perr, ferr, ovf, busy,
        input  rd_strobe
    );

    modport slave (
        input  data, rx_rdy, perr, ferr, ovf, busy,
        output rd_strobe
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronised rx, start detection with false-start
// rejection, mid-bit sampling, 5-8 data bits, optional parity, 1/2 stop bits.
module uart_rx_engine #(
    parameter int BAUD_W      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [BAUD_W-1:0] baud,
    input  logic [1:0]        data_len,
    input  logic              pen,
    input  logic              odd,
    input  logic              stop2,
    uart_rx_engine_if.master  bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_prev;
    logic                   start, btu, last_bit;

    logic [BAUD_W-1:0] baud_l, cnt, target;
    logic [1:0]        len_l;
    logic              pen_l, odd_l, stop2_l;

    logic [2:0] idx;
    logic [7:0] shreg;
    logic       pbit, ferr_acc, stop_second, done;

    logic [7:0] data_q;
    logic       rx_rdy_q, perr_q, ferr_q, ovf_q;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign start    = (state_q == IDLE) && rxs_prev && !rxs;
    assign target   = (state_q == START) ? (baud_l >> 1) : baud_l;
    assign btu      = (state_q != IDLE) && (cnt == target - 1'b1);
    assign last_bit = (idx == {1'b0, len_l} + 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '1;
            rxs_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = START;
            START:  if (btu) state_d = rxs ? IDLE : DATA;
            DATA:   if (btu && last_bit) state_d = pen_l ? PARITY : STOP;
            PARITY: if (btu) state_d = STOP;
            STOP:   if (btu && (!stop2_l || stop_second)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath; config is captured on the start edge so mid-frame changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            baud_l      <= '0;
            len_l       <= '0;
            pen_l       <= 1'b0;
            odd_l       <= 1'b0;
            stop2_l     <= 1'b0;
            idx         <= '0;
            shreg       <= '0;
            pbit        <= 1'b0;
            ferr_acc    <= 1'b0;
            stop_second <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt         <= '0;
                baud_l      <= baud;
                len_l       <= data_len;
                pen_l       <= pen;
                odd_l       <= odd;
                stop2_l     <= stop2;
                idx         <= '0;
                shreg       <= '0;
                pbit        <= 1'b0;
                ferr_acc    <= 1'b0;
                stop_second <= 1'b0;
            end else if (state_q != IDLE) begin
                cnt <= btu ? '0 : cnt + 1'b1;
            end

            if (btu) begin
                case (state_q)
                    DATA: begin
                        shreg[idx] <= rxs;
                        idx        <= idx + 3'd1;
                    end
                    PARITY: pbit <= rxs;
                    STOP: begin
                        ferr_acc    <= ferr_acc | !rxs;
                        stop_second <= 1'b1;
                        if (!stop2_l || stop_second) done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Completion takes priority over a coincident read; ovf then stays clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            rx_rdy_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (done) begin
            data_q   <= shreg;
            perr_q   <= pen_l & ((^shreg ^ pbit) != odd_l);
            ferr_q   <= ferr_acc;
            rx_rdy_q <= 1'b1;
            ovf_q    <= (ovf_q | rx_rdy_q) & !bus.rd_strobe;
        end else if (bus.rd_strobe) begin
            rx_rdy_q <= 1'b0;
            ovf_q    <= 1'b0;
        end
    end

    assign bus.data   = data_q;
    assign bus.rx_rdy = rx_rdy_q;
    assign bus.perr   = perr_q;
    assign bus.ferr   = ferr_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: frames are driven serially and the
// expected character/flags are queued and compared when rx_rdy is seen.
module tb_uart_rx_engine;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [19:0] baud;
    logic [1:0]  data_len;
    logic        pen, odd, stop2;

    uart_rx_engine_if bus ();

    uart_rx_engine #(.BAUD_W(20), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .baud     (baud),
        .data_len (data_len),
        .pen      (pen),
        .odd      (odd),
        .stop2    (stop2),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    task automatic set_cfg(input logic [1:0] len, input logic p, input logic o, input logic s2);
        data_len = len;
        pen      = p;
        odd      = o;
        stop2    = s2;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par,
                              input logic pb, input logic s1, input logic s2, input bit two);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par) drive_bit(pb);
        drive_bit(s1);
        if (two) drive_bit(s2);
    endtask

    // Reference model of one received character.
    task automatic push_exp(input logic [7:0] d, input int nbits, input bit par, input bit o,
                            input logic pb, input logic s1, input logic s2, input bit two,
                            input logic ov);
        logic [8:0] mask;
        logic [7:0] m;
        exp_t e;
        mask   = (9'h1 << nbits) - 9'h1;
        m      = d & mask[7:0];
        e.data = m;
        e.perr = par && ((^m ^ pb) != o);
        e.ferr = !s1 || (two && !s2);
        e.ovf  = ov;
        sb.push_back(e);
    endtask

    task automatic wait_rdy(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        @(negedge clk);
        while (!ok && n < 4 * BAUD) begin
            if (bus.rx_rdy === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic read_strobe();
        @(posedge clk);
        #1 bus.rd_strobe = 1'b1;
        @(posedge clk);
        #1 bus.rd_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        reset = 1'b1;
        rx = 1'b1;
        bus.rd_strobe = 1'b0;
        baud = 20'(BAUD);
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {bus.data, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, bus.busy};
        checks++;
        if (got !== 13'h0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0000", got);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        got = {bus.data, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, bus.busy};
        checks++;
        if (got !== 13'h0) begin
            errors++;
            $display("FAIL post_reset_idle got %h exp 0000", got);
        end
    endtask

    task automatic test_8n1();
        logic [7:0] pats [4];
        exp_t got, e;
        bit ok;
        pats = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        foreach (pats[k]) begin
            idle(BAUD);
            push_exp(pats[k], 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
            send_frame(pats[k], 8, 0, 1'b0, 1'b1, 1'b1, 0);
            wait_rdy(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL 8n1_rdy_timeout got 0 exp 1");
            end
            got = {bus.data, bus.perr, bus.ferr, bus.ovf};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL 8n1_char got %h exp %h", got, e);
            end
            read_strobe();
            checks++;
            if (bus.rx_rdy !== 1'b0 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL 8n1_read_clear got rdy=%b ovf=%b exp 0 0", bus.rx_rdy, bus.ovf);
            end
        end
    endtask

    task automatic test_parity();
        logic [2:0] tbl [3];
        exp_t got, e;
        bit ok;
        // {odd, parity bit, unused}: 7E1 bad, 7E1 good, 7O1 good for 0x41
        tbl = '{3'b010, 3'b000, 3'b110};
        foreach (tbl[k]) begin
            set_cfg(2'b10, 1'b1, tbl[k][2], 1'b0);
            idle(BAUD);
            push_exp(8'h41, 7, 1, tbl[k][2], tbl[k][1], 1'b1, 1'b1, 0, 1'b0);
            send_frame(8'h41, 7, 1, tbl[k][1], 1'b1, 1'b1, 0);
            wait_rdy(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL parity_rdy_timeout got 0 exp 1");
            end
            got = {bus.data, bus.perr, bus.ferr, bus.ovf};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL parity_char case %0d got %h exp %h", k, got, e);
            end
            read_strobe();
        end
    endtask

    task automatic test_framing();
        exp_t got, e;
        bit ok;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(BAUD);
        push_exp(8'h3C, 8, 0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h3C, 8, 0, 1'b0, 1'b0, 1'b1, 0);
        wait_rdy(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ferr_rdy_timeout got 0 exp 1");
        end
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ferr_char got %h exp %h", got, e);
        end
        read_strobe();
        repeat (3 * BAUD) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL break_no_retrigger got busy=%b rdy=%b exp 0 0", bus.busy, bus.rx_rdy);
        end
        idle(BAUD);
        push_exp(8'h5A, 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 1'b1, 0);
        wait_rdy(ok);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL after_break_char got %h rdy=%b exp %h", got, ok, e);
        end
        read_strobe();
    endtask

    task automatic test_false_start();
        int busy_cycles;
        busy_cycles = 0;
        idle(BAUD);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx = (i < 4) ? 1'b0 : 1'b1;
            if (bus.busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL false_start_busy got %0d exp 8", busy_cycles);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL false_start_idle got busy=%b rdy=%b exp 0 0", bus.busy, bus.rx_rdy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        bit ok;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(BAUD);
        push_exp(8'h11, 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h11, 8, 0, 1'b0, 1'b1, 1'b1, 0);
        wait_rdy(ok);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL b2b_first got %h rdy=%b exp %h", got, ok, e);
        end
        push_exp(8'h22, 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        send_frame(8'h22, 8, 0, 1'b0, 1'b1, 1'b1, 0);
        idle(4);
        @(negedge clk);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL overrun_char got %h exp %h", got, e);
        end
        read_strobe();
        checks++;
        if (bus.rx_rdy !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got rdy=%b ovf=%b exp 0 0", bus.rx_rdy, bus.ovf);
        end
    endtask

    task automatic test_config_latch();
        exp_t got, e;
        bit ok;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(BAUD);
        push_exp(8'hC3, 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        fork
            send_frame(8'hC3, 8, 0, 1'b0, 1'b1, 1'b1, 0);
            begin
                repeat (3 * BAUD) @(posedge clk);
                #2 set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
            end
        join
        wait_rdy(ok);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL cfg_latch_char got %h rdy=%b exp %h", got, ok, e);
        end
        read_strobe();
    endtask

    task automatic test_5o2_reset();
        exp_t got, e;
        logic [12:0] outs;
        bit ok;
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
        idle(BAUD);
        push_exp(8'h15, 5, 1, 1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        send_frame(8'h15, 5, 1, 1'b0, 1'b1, 1'b0, 1);
        wait_rdy(ok);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL 5o2_char got %h rdy=%b exp %h", got, ok, e);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        idle(2 * BAUD);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_busy got %b exp 1", bus.busy);
        end
        reset = 1'b1;
        rx = 1'b1;
        #1;
        outs = {bus.data, bus.rx_rdy, bus.perr, bus.ferr, bus.ovf, bus.busy};
        checks++;
        if (outs !== 13'h0) begin
            errors++;
            $display("FAIL mid_frame_reset got %h exp 0000", outs);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(2 * BAUD);
        push_exp(8'h96, 8, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'h96, 8, 0, 1'b0, 1'b1, 1'b1, 0);
        wait_rdy(ok);
        got = {bus.data, bus.perr, bus.ferr, bus.ovf};
        e = sb.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL after_reset_char got %h rdy=%b exp %h", got, ok, e);
        end
        read_strobe();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_config_latch();
        test_5o2_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
